// File: rtl/cpu_types_pkg.sv
// -----------------------------------------------------------------------------
// cpu_types_pkg
// Shared types for the request unit: the controller state encoding and the
// default width of the performance counters.
// -----------------------------------------------------------------------------
package cpu_types_pkg;

    // Default performance counter width.
    localparam int CNTW_DEF = 32;

    // Request unit controller states.
    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DATA   = 2'd1,
        HALTED = 2'd2
    } rustate_t;

endpackage

// File: rtl/request_unit_if.sv
// -----------------------------------------------------------------------------
// request_unit_if
// Bundles the control-unit decode inputs, the memory hit inputs, the memory
// request / PC strobe outputs and the performance counters of request_unit.
//   ru : the request unit side (decode and hits in, requests and counters out)
//   tb : the driving side (mirror image of ru)
// -----------------------------------------------------------------------------
interface request_unit_if
    import cpu_types_pkg::*;
#(
    parameter int CNTW = CNTW_DEF
);
    logic            dMemREN;
    logic            dMemWEN;
    logic            Halt;
    logic            ihit;
    logic            dhit;
    logic            imemREN;
    logic            dmemREN;
    logic            dmemWEN;
    logic            pcEN;
    logic            halt;
    logic [CNTW-1:0] instr_cnt;
    logic [CNTW-1:0] stall_cnt;

    modport ru (
        input  dMemREN, dMemWEN, Halt, ihit, dhit,
        output imemREN, dmemREN, dmemWEN, pcEN, halt, instr_cnt, stall_cnt
    );

    modport tb (
        output dMemREN, dMemWEN, Halt, ihit, dhit,
        input  imemREN, dmemREN, dmemWEN, pcEN, halt, instr_cnt, stall_cnt
    );
endinterface

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that sticks at all-ones instead of wrapping.
//   CLK   : clock, rising edge
//   nRST  : asynchronous active-low reset, clears the count
//   inc_i : count enable for this cycle
//   cnt_o : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/request_unit.sv
// -----------------------------------------------------------------------------
// request_unit
// Sequences instruction fetch and data memory access for a single-issue core.
// FETCH waits for ihit; a decoded load/store moves to DATA until dhit; a
// decoded halt moves to HALTED, which only reset leaves. Also keeps a retired
// instruction counter (wrapping) and a memory stall counter (saturating).
//   CLK, nRST : clock (rising edge) and asynchronous active-low reset
//   ruif.ru   : dMemREN/dMemWEN/Halt decode, ihit/dhit in;
//               imemREN/dmemREN/dmemWEN/pcEN/halt, instr_cnt/stall_cnt out
// -----------------------------------------------------------------------------
module request_unit
    import cpu_types_pkg::*;
#(
    parameter int CNTW = CNTW_DEF
) (
    input  logic      CLK,
    input  logic      nRST,
    request_unit_if.ru ruif
);
    rustate_t        state_q, state_d;
    logic            dren_q, dren_d;
    logic            dwen_q, dwen_d;
    logic [CNTW-1:0] icnt_q;
    logic            in_fetch, in_data;
    logic            pc_en;
    logic            stall_inc;

    assign in_fetch = (state_q == FETCH);
    assign in_data  = (state_q == DATA);

    // Decode inputs are only looked at in FETCH; in DATA only dhit matters.
    always_comb begin
        state_d = state_q;
        dren_d  = dren_q;
        dwen_d  = dwen_q;
        unique case (state_q)
            FETCH: begin
                if (ruif.ihit) begin
                    if (ruif.Halt) begin
                        state_d = HALTED;
                    end else if (ruif.dMemREN | ruif.dMemWEN) begin
                        state_d = DATA;
                        // Load and store both decoded: the store wins.
                        dwen_d  = ruif.dMemWEN;
                        dren_d  = ruif.dMemREN & ~ruif.dMemWEN;
                    end
                end
            end
            DATA: begin
                if (ruif.dhit) begin
                    state_d = FETCH;
                    dren_d  = 1'b0;
                    dwen_d  = 1'b0;
                end
            end
            default: ;  // HALTED holds until reset
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= FETCH;
            dren_q  <= 1'b0;
            dwen_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dren_q  <= dren_d;
            dwen_q  <= dwen_d;
        end
    end

    // Gated by nRST so a hit seen while reset is held never strobes the PC.
    assign pc_en = nRST &
                   ((in_fetch & ruif.ihit & ~ruif.Halt & ~ruif.dMemREN & ~ruif.dMemWEN) |
                    (in_data  & ruif.dhit));

    assign stall_inc = (in_fetch & ~ruif.ihit) | (in_data & ~ruif.dhit);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST)      icnt_q <= '0;
        else if (pc_en) icnt_q <= icnt_q + 1'b1;
    end

    sat_counter #(.W(CNTW)) u_stall_cnt (
        .CLK   (CLK),
        .nRST  (nRST),
        .inc_i (stall_inc),
        .cnt_o (ruif.stall_cnt)
    );

    assign ruif.imemREN   = in_fetch;
    assign ruif.dmemREN   = dren_q;
    assign ruif.dmemWEN   = dwen_q;
    assign ruif.pcEN      = pc_en;
    assign ruif.halt      = (state_q == HALTED);
    assign ruif.instr_cnt = icnt_q;
endmodule
